uc_arbiter: RTL and testbench
=============================

Name: uc_arbiter

Overview:
- Shares the single unit-clause queue write port (uc_queue push/uca2ucq/full) among N_REQ BCP engines that produce implied unit literals.
- Grants one requester per cycle, round-robin, and presents the literal to the queue combinationally.
- Filters duplicates against a short history of recently pushed literals.
- Detects an opposite-polarity literal in the history as a conflict and halts granting until flush or reset.

Parameters:
- N_REQ, 4, number of requesting engines (>=2).
- UC_LENGTH, 512, literal encoding space; LW = $clog2(UC_LENGTH) = 9; literal bit0 = polarity, bits[LW-1:1] = variable.
- HIST_DEPTH, 4, number of most-recently-pushed literals kept for dup/conflict check.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-engine request; held with lit stable until ack.
- lit  in  N_REQ x LW  per-engine literal.
- ack  out  N_REQ  one-hot (or zero); literal consumed this cycle, whether pushed or dropped.
- full  in  1  uc_queue full.
- push  out  1  write strobe to uc_queue.
- uca2ucq  out  LW  literal to uc_queue; 0 when push=0.
- flush  in  1  start of new decision level: clears history/conflict/pointer/count.
- conflict  out  1  sticky conflict flag.
- conflict_lit  out  LW  literal that caused the first conflict.
- push_cnt  out  16  literals pushed since reset/flush, saturating at 16'hFFFF.

Behaviour:
- State: rr_ptr (clog2(N_REQ) bits), hist_lit[HIST_DEPTH], hist_vld[HIST_DEPTH], conflict, conflict_lit, push_cnt.
- Reset (rst=1 at posedge) clears all state to 0. While rst=1, ack, push and uca2ucq are forced to 0.
- Grant enable: grant_en = !rst & !flush & !full & !conflict.
- Winner selection:
  - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - If grant_en and a winner exists: ack[winner]=1 combinationally (zero latency), all other ack bits 0.
- Duplicate/conflict check on the winner's literal W, against valid history entries:
  - dup = W equals any valid hist_lit.
  - opp = (W ^ 1) equals any valid hist_lit.
  - dup and opp are mutually exclusive by construction.
- Push rule:
  - push = ack_any & !dup & !opp; uca2ucq = W when push, else 0.
  - The queue captures on the same posedge.
- On a posedge with ack_any:
  - rr_ptr <= (winner + 1) mod N_REQ.
  - If push: shift W into hist_lit[0] with valid=1, older entries shift toward HIST_DEPTH-1, the oldest is discarded, and push_cnt increments (saturating).
  - If dup: literal dropped; history, push_cnt and conflict unchanged.
  - If opp: conflict <= 1 and conflict_lit <= W; no push, history unchanged.
- Conflict is sticky:
  - While conflict=1, no acks are issued; requesters stall holding req.
  - Only flush or rst clears it. conflict_lit holds the first conflicting literal.
- flush=1 at posedge: hist_vld all 0, conflict=0, conflict_lit=0, rr_ptr=0, push_cnt=0. No ack or push occurs in a flush cycle.
- full=1: no ack and no push; rr_ptr and history hold; requests wait with no loss.
- rst has priority over flush. Reset mid-stream abandons any held request; the engine re-requests after reset.
- No requester is starved: a requester holding req is acked within N_REQ grant-enabled cycles.

Test Plan:
- Basic grant: after reset, req=4'b0100, lit[2]=10 -> same cycle ack=4'b0100, push=1, uca2ucq=10. Next cycle push_cnt=1 and rr_ptr=3.
- Round-robin: req=4'b1111 held with lits 2,4,6,8, each dropping req after its ack -> acks 0,1,2,3 on consecutive cycles, pushes 2,4,6,8, push_cnt=4.
- Backpressure: full=1 with req[1]=1, lit=12, for 3 cycles -> ack=0, push=0. full=0 -> ack[1]=1, push=1, uca2ucq=12.
- Duplicate: push 20, then req[0] with lit 20 -> ack[0]=1, push=0, push_cnt unchanged.
- Conflict: push 20, then req[3] with lit 21 -> ack[3]=1, push=0. Next cycle conflict=1, conflict_lit=21. Further reqs get ack=0. flush pulse -> conflict=0, push_cnt=0; then lit 21 is pushed.
- History eviction: push 2,4,6,8,10 (HIST_DEPTH=4), then request 2 -> push=1 (evicted, not a dup). Then request 10 -> push=0 (dup).

Source files
------------

// File: rtl/uc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uc_arbiter
// Brief    : Round-robin arbiter for the unit-clause queue write port, with
//            duplicate filtering and opposite-polarity conflict detection.
// Revision : 1.0 - initial release
// ============================================================================
module uc_arbiter #(
    parameter int N_REQ      = 4,
    parameter int UC_LENGTH  = 512,
    parameter int HIST_DEPTH = 4,
    parameter int LW         = $clog2(UC_LENGTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0][LW-1:0]  lit,
    output logic [N_REQ-1:0]          ack,
    input  logic                      full,
    output logic                      push,
    output logic [LW-1:0]             uca2ucq,
    input  logic                      flush,
    output logic                      conflict,
    output logic [LW-1:0]             conflict_lit,
    output logic [15:0]               push_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] r_rr_ptr;
    logic [LW-1:0] r_hist_lit [HIST_DEPTH];
    logic          r_hist_vld [HIST_DEPTH];
    logic          r_conflict;
    logic [LW-1:0] r_conflict_lit;
    logic [15:0]   r_push_cnt;

    logic          w_grant_en;
    logic          w_any;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_next_ptr;
    logic [LW-1:0] w_win_lit;
    logic [LW-1:0] w_opp_lit;
    logic          w_dup;
    logic          w_opp;
    logic          w_ack_any;
    logic          w_push;

    assign w_grant_en = !rst && !flush && !full && !r_conflict;

    // Scan offsets from the far end so the nearest requester to r_rr_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (req[idx]) begin
                w_any = 1'b1;
                w_win = PW'(idx);
            end
        end
    end

    assign w_win_lit  = lit[w_win];
    assign w_opp_lit  = {w_win_lit[LW-1:1], ~w_win_lit[0]};
    assign w_next_ptr = (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_dup = 1'b0;
        w_opp = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (r_hist_vld[i] && (r_hist_lit[i] == w_win_lit)) w_dup = 1'b1;
            if (r_hist_vld[i] && (r_hist_lit[i] == w_opp_lit)) w_opp = 1'b1;
        end
    end

    assign w_ack_any = w_grant_en && w_any;
    assign w_push    = w_ack_any && !w_dup && !w_opp;

    always_comb begin
        ack = '0;
        if (w_ack_any) ack[w_win] = 1'b1;
    end

    assign push         = w_push;
    assign uca2ucq      = w_push ? w_win_lit : '0;
    assign conflict     = r_conflict;
    assign conflict_lit = r_conflict_lit;
    assign push_cnt     = r_push_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            r_conflict     <= 1'b0;
            r_conflict_lit <= '0;
            r_push_cnt     <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hist_lit[i] <= '0;
                r_hist_vld[i] <= 1'b0;
            end
        end else if (flush) begin
            r_rr_ptr       <= '0;
            r_conflict     <= 1'b0;
            r_conflict_lit <= '0;
            r_push_cnt     <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hist_vld[i] <= 1'b0;
            end
        end else if (w_ack_any) begin
            r_rr_ptr <= w_next_ptr;
            if (w_push) begin
                r_hist_lit[0] <= w_win_lit;
                r_hist_vld[0] <= 1'b1;
                for (int i = 1; i < HIST_DEPTH; i++) begin
                    r_hist_lit[i] <= r_hist_lit[i-1];
                    r_hist_vld[i] <= r_hist_vld[i-1];
                end
                if (r_push_cnt != 16'hFFFF) r_push_cnt <= r_push_cnt + 16'd1;
            end else if (w_opp) begin
                r_conflict     <= 1'b1;
                r_conflict_lit <= w_win_lit;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uc_arbiter
// Brief    : Table-driven directed bench for uc_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uc_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [3:0][8:0]  lit;
    logic [3:0]       ack;
    logic             full;
    logic             push;
    logic [8:0]       uca2ucq;
    logic             flush;
    logic             conflict;
    logic [8:0]       conflict_lit;
    logic [15:0]      push_cnt;

    uc_arbiter #(.N_REQ(4), .UC_LENGTH(512), .HIST_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .req(req), .lit(lit), .ack(ack), .full(full),
        .push(push), .uca2ucq(uca2ucq), .flush(flush), .conflict(conflict),
        .conflict_lit(conflict_lit), .push_cnt(push_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            flush;
        logic            full;
        logic [3:0]      req;
        logic [3:0][8:0] lits;
        logic [3:0]      e_ack;
        logic            e_push;
        logic [8:0]      e_uca;
        logic            e_conf;
        logic [8:0]      e_clit;
        logic [15:0]     e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic r, input logic fl, input logic fu,
                                input logic [3:0] rq, input int l0, input int l1,
                                input int l2, input int l3, input logic [3:0] ea,
                                input logic ep, input int eu, input logic ec,
                                input int ecl, input int ecnt);
        vec_t v;
        v.rst = r; v.flush = fl; v.full = fu; v.req = rq;
        v.lits[0] = 9'(l0); v.lits[1] = 9'(l1); v.lits[2] = 9'(l2); v.lits[3] = 9'(l3);
        v.e_ack = ea; v.e_push = ep; v.e_uca = 9'(eu);
        v.e_conf = ec; v.e_clit = 9'(ecl); v.e_cnt = 16'(ecnt);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL vec%0d %s: got %0h expected %0h", idx, name, got, exp);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        n_vec++;
        chk("ack",          idx, 32'(ack),          32'(v.e_ack));
        chk("push",         idx, 32'(push),         32'(v.e_push));
        chk("uca2ucq",      idx, 32'(uca2ucq),      32'(v.e_uca));
        chk("conflict",     idx, 32'(conflict),     32'(v.e_conf));
        chk("conflict_lit", idx, 32'(conflict_lit), 32'(v.e_clit));
        chk("push_cnt",     idx, 32'(push_cnt),     32'(v.e_cnt));
    endtask

    initial begin
        // rst flush full req  l0 l1 l2 l3   ack  push uca conf clit cnt
        tbl.push_back(mk(1,0,0,4'b1111, 1, 1, 1, 1, 4'b0000,0, 0,0, 0,0)); // 0 reset forces zeros
        tbl.push_back(mk(0,0,0,4'b0100, 0, 0,10, 0, 4'b0100,1,10,0, 0,0)); // 1 basic grant
        tbl.push_back(mk(0,0,0,4'b1001,30, 0, 0,32, 4'b1000,1,32,0, 0,1)); // 2 rr_ptr=3 favours req3
        tbl.push_back(mk(0,0,0,4'b0001,30, 0, 0, 0, 4'b0001,1,30,0, 0,2)); // 3
        tbl.push_back(mk(0,1,0,4'b1111, 2, 4, 6, 8, 4'b0000,0, 0,0, 0,3)); // 4 flush: no ack
        tbl.push_back(mk(0,0,0,4'b1111, 2, 4, 6, 8, 4'b0001,1, 2,0, 0,0)); // 5 round robin
        tbl.push_back(mk(0,0,0,4'b1110, 2, 4, 6, 8, 4'b0010,1, 4,0, 0,1)); // 6
        tbl.push_back(mk(0,0,0,4'b1100, 2, 4, 6, 8, 4'b0100,1, 6,0, 0,2)); // 7
        tbl.push_back(mk(0,0,0,4'b1000, 2, 4, 6, 8, 4'b1000,1, 8,0, 0,3)); // 8
        tbl.push_back(mk(0,0,0,4'b0000, 0, 0, 0, 0, 4'b0000,0, 0,0, 0,4)); // 9
        tbl.push_back(mk(0,0,0,4'b0001,10, 0, 0, 0, 4'b0001,1,10,0, 0,4)); // 10 evicts 2
        tbl.push_back(mk(0,0,0,4'b0001, 2, 0, 0, 0, 4'b0001,1, 2,0, 0,5)); // 11 2 no longer dup
        tbl.push_back(mk(0,0,0,4'b0001,10, 0, 0, 0, 4'b0001,0, 0,0, 0,6)); // 12 10 is dup
        tbl.push_back(mk(0,0,0,4'b0000, 0, 0, 0, 0, 4'b0000,0, 0,0, 0,6)); // 13
        tbl.push_back(mk(0,0,1,4'b0010, 0,12, 0, 0, 4'b0000,0, 0,0, 0,6)); // 14 backpressure
        tbl.push_back(mk(0,0,1,4'b0010, 0,12, 0, 0, 4'b0000,0, 0,0, 0,6)); // 15
        tbl.push_back(mk(0,0,1,4'b0010, 0,12, 0, 0, 4'b0000,0, 0,0, 0,6)); // 16
        tbl.push_back(mk(0,0,0,4'b0010, 0,12, 0, 0, 4'b0010,1,12,0, 0,6)); // 17 full released
        tbl.push_back(mk(0,0,0,4'b0001,20, 0, 0, 0, 4'b0001,1,20,0, 0,7)); // 18
        tbl.push_back(mk(0,0,0,4'b0001,20, 0, 0, 0, 4'b0001,0, 0,0, 0,8)); // 19 duplicate
        tbl.push_back(mk(0,0,0,4'b0000, 0, 0, 0, 0, 4'b0000,0, 0,0, 0,8)); // 20 cnt unchanged
        tbl.push_back(mk(0,0,0,4'b1000, 0, 0, 0,21, 4'b1000,0, 0,0, 0,8)); // 21 opposite of 20
        tbl.push_back(mk(0,0,0,4'b1001,40, 0, 0,21, 4'b0000,0, 0,1,21,8)); // 22 sticky conflict
        tbl.push_back(mk(0,0,0,4'b1001,40, 0, 0,21, 4'b0000,0, 0,1,21,8)); // 23
        tbl.push_back(mk(0,1,0,4'b1000, 0, 0, 0,21, 4'b0000,0, 0,1,21,8)); // 24 flush
        tbl.push_back(mk(0,0,0,4'b1000, 0, 0, 0,21, 4'b1000,1,21,0, 0,0)); // 25 21 now pushed
        tbl.push_back(mk(0,0,0,4'b0000, 0, 0, 0, 0, 4'b0000,0, 0,0, 0,1)); // 26
        tbl.push_back(mk(1,1,0,4'b0001, 5, 0, 0, 0, 4'b0000,0, 0,0, 0,1)); // 27 rst over flush
        tbl.push_back(mk(0,0,0,4'b0000, 0, 0, 0, 0, 4'b0000,0, 0,0, 0,0)); // 28

        rst = 1'b1; flush = 1'b0; full = 1'b0; req = '0; lit = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; flush = tbl[i].flush; full = tbl[i].full;
            req = tbl[i].req; lit = tbl[i].lits;
            #2;
            check_vec(i, tbl[i]);
            @(negedge clk);
        end

        // Fairness: all four hold requests from rr_ptr=0; req2 must win on the third cycle.
        begin
            int cyc;
            bit seen;
            logic [8:0] exp_uca;
            seen = 1'b0;
            cyc  = 0;
            req  = 4'b1111;
            lit[0] = 9'd100; lit[1] = 9'd102; lit[2] = 9'd104; lit[3] = 9'd106;
            while (!seen && cyc < 8) begin
                #2;
                exp_uca = 9'(100 + 2 * cyc);
                n_vec++;
                chk("rr_uca", 100 + cyc, 32'(uca2ucq), 32'(exp_uca));
                if (ack[2]) seen = 1'b1;
                else begin
                    cyc++;
                    @(negedge clk);
                end
            end
            chk("rr_fair_cycles", 100, 32'(cyc), 32'd2);
            @(negedge clk);
            req = '0;
            #2;
            n_vec++;
            chk("rr_push_cnt", 110, 32'(push_cnt), 32'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
